// File: rtl/stream_pattern_gen.sv
// stream_pattern_gen
//   Frame-structured test-pattern source. Each frame is emitted as one word per
//   cycle with a dtype tag: FRAME_START, HEADER_START, HEADER_WORDS header words,
//   HEADER_END, then per row ROW_START, num_cols pixels, ROW_END and a row gap.
//   After the last row's gap comes FRAME_END followed by a frame gap.
//   All outputs are registered.
//
// Optional build macro:
//   STREAM_PATTERN_GEN_FRAME_COUNT_EN - adds a DATA_WIDTH frame counter. It is
//   reported on header word HEADER_WORDS-1.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   enable       in   permits a frame to start
//   num_cols     in   pixels per row (latched at frame start)
//   num_rows     in   rows per frame (latched at frame start)
//   pattern_sel  in   0 const, 1 col ramp, 2 row ramp, 3 diagonal
//   const_value  in   pixel value for pattern 0
//   dvo          out  data valid
//   dtypeo       out  dtype tag of the current word
//   datao        out  pixel data (pixel words only)
//   meta_datao   out  header data (header words only)
//   busy         out  high from FRAME_START through the end of the frame gap

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH        4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START  4'd1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END    4'd2
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START    4'd3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END      4'd4
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 4'd5
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER       4'd6
`endif
`ifndef DTYPE_HEADER_END
`define DTYPE_HEADER_END   4'd7
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL        4'd8
`endif
`ifndef Image_num_cols
`define Image_num_cols     1
`endif
`ifndef Image_num_rows
`define Image_num_rows     2
`endif

module stream_pattern_gen #(
    parameter int PIXEL_WIDTH    = 10,
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_COLS_WIDTH = 11,
    parameter int HEADER_WORDS   = 8,
    parameter int ROW_GAP        = 4,
    parameter int FRAME_GAP      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_COLS_WIDTH-1:0] num_cols,
    input  logic [NUM_COLS_WIDTH-1:0] num_rows,
    input  logic [1:0]                pattern_sel,
    input  logic [PIXEL_WIDTH-1:0]    const_value,
    output logic                      dvo,
    output logic [`DTYPE_WIDTH-1:0]   dtypeo,
    output logic [PIXEL_WIDTH-1:0]    datao,
    output logic [DATA_WIDTH-1:0]     meta_datao,
    output logic                      busy
);

    // Shared counter for header index, row gap and frame gap.
    localparam int CNT_W = 16;

    typedef enum logic [3:0] {
        IDLE, FSTART, HSTART, HDR, HEND, RSTART, PIX, REND, RGAP, FEND, FGAP
    } state_t;

    state_t                    r_state, w_nxt_state;
    logic [CNT_W-1:0]          r_cnt, w_nxt_cnt;
    logic [NUM_COLS_WIDTH-1:0] r_row, w_nxt_row;
    logic [NUM_COLS_WIDTH-1:0] r_col, w_nxt_col;

    logic [NUM_COLS_WIDTH-1:0] r_num_cols, r_num_rows;
    logic [1:0]                r_pat;
    logic [PIXEL_WIDTH-1:0]    r_const;

    logic                      r_dvo, w_dvo;
    logic [`DTYPE_WIDTH-1:0]   r_dtype, w_dtype;
    logic [PIXEL_WIDTH-1:0]    r_data, w_data;
    logic [DATA_WIDTH-1:0]     r_meta, w_meta;
    logic                      r_busy, w_busy;

    logic                      w_start;
    logic                      w_last_row;
    logic                      w_load;

`ifdef STREAM_PATTERN_GEN_FRAME_COUNT_EN
    logic [DATA_WIDTH-1:0]     r_frame_cnt;
`endif

    assign w_start    = enable && (num_cols != '0) && (num_rows != '0);
    assign w_last_row = (r_row == r_num_rows - NUM_COLS_WIDTH'(1));
    // Frame parameters are captured only on entry to FSTART, so mid-frame
    // input changes have no effect.
    assign w_load     = (w_nxt_state == FSTART);

    // Next-state logic. Outputs are decoded from the *next* state/counters so
    // that the registered outputs line up with r_state.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_row   = r_row;
        w_nxt_col   = r_col;
        case (r_state)
            IDLE:   if (w_start) w_nxt_state = FSTART;
            FSTART: w_nxt_state = HSTART;
            HSTART: begin
                w_nxt_state = HDR;
                w_nxt_cnt   = '0;
            end
            HDR: begin
                if (r_cnt == CNT_W'(HEADER_WORDS - 1)) w_nxt_state = HEND;
                else                                   w_nxt_cnt   = r_cnt + CNT_W'(1);
            end
            HEND: begin
                w_nxt_state = RSTART;
                w_nxt_row   = '0;
            end
            RSTART: begin
                w_nxt_state = PIX;
                w_nxt_col   = '0;
            end
            PIX: begin
                if (r_col == r_num_cols - NUM_COLS_WIDTH'(1)) w_nxt_state = REND;
                else                                          w_nxt_col   = r_col + NUM_COLS_WIDTH'(1);
            end
            REND, RGAP: begin
                if (r_state == REND && ROW_GAP != 0) begin
                    w_nxt_state = RGAP;
                    w_nxt_cnt   = '0;
                end else if (r_state == RGAP && r_cnt != CNT_W'(ROW_GAP - 1)) begin
                    w_nxt_cnt   = r_cnt + CNT_W'(1);
                end else if (w_last_row) begin
                    w_nxt_state = FEND;
                end else begin
                    w_nxt_state = RSTART;
                    w_nxt_row   = r_row + NUM_COLS_WIDTH'(1);
                end
            end
            FEND, FGAP: begin
                if (r_state == FEND && FRAME_GAP != 0) begin
                    w_nxt_state = FGAP;
                    w_nxt_cnt   = '0;
                end else if (r_state == FGAP && r_cnt != CNT_W'(FRAME_GAP - 1)) begin
                    w_nxt_cnt   = r_cnt + CNT_W'(1);
                end else begin
                    // Back-to-back frames skip IDLE entirely.
                    w_nxt_state = w_start ? FSTART : IDLE;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // Output decode for the word that will be presented next cycle.
    always_comb begin
        w_dvo   = 1'b1;
        w_dtype = '0;
        w_data  = '0;
        w_meta  = '0;
        w_busy  = (w_nxt_state != IDLE);
        case (w_nxt_state)
            FSTART: w_dtype = `DTYPE_FRAME_START;
            HSTART: w_dtype = `DTYPE_HEADER_START;
            HDR: begin
                w_dtype = `DTYPE_HEADER;
                if (w_nxt_cnt == CNT_W'(`Image_num_cols))
                    w_meta = DATA_WIDTH'(r_num_cols);
                else if (w_nxt_cnt == CNT_W'(`Image_num_rows))
                    w_meta = DATA_WIDTH'(r_num_rows);
`ifdef STREAM_PATTERN_GEN_FRAME_COUNT_EN
                else if (w_nxt_cnt == CNT_W'(HEADER_WORDS - 1))
                    w_meta = r_frame_cnt;
`endif
            end
            HEND:   w_dtype = `DTYPE_HEADER_END;
            RSTART: w_dtype = `DTYPE_ROW_START;
            PIX: begin
                w_dtype = `DTYPE_PIXEL;
                case (r_pat)
                    2'd0:    w_data = r_const;
                    2'd1:    w_data = PIXEL_WIDTH'(w_nxt_col);
                    2'd2:    w_data = PIXEL_WIDTH'(w_nxt_row);
                    default: w_data = PIXEL_WIDTH'(w_nxt_row) + PIXEL_WIDTH'(w_nxt_col);
                endcase
            end
            REND:   w_dtype = `DTYPE_ROW_END;
            FEND:   w_dtype = `DTYPE_FRAME_END;
            default: w_dvo  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_num_cols <= '0;
            r_num_rows <= '0;
            r_pat      <= '0;
            r_const    <= '0;
            r_dvo      <= 1'b0;
            r_dtype    <= '0;
            r_data     <= '0;
            r_meta     <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_row   <= w_nxt_row;
            r_col   <= w_nxt_col;
            if (w_load) begin
                r_num_cols <= num_cols;
                r_num_rows <= num_rows;
                r_pat      <= pattern_sel;
                r_const    <= const_value;
            end
            r_dvo   <= w_dvo;
            r_dtype <= w_dtype;
            r_data  <= w_data;
            r_meta  <= w_meta;
            r_busy  <= w_busy;
        end
    end

`ifdef STREAM_PATTERN_GEN_FRAME_COUNT_EN
    // Counts completed frames; aborted frames (reset) never reach FEND.
    always_ff @(posedge clk) begin
        if (reset)                r_frame_cnt <= '0;
        else if (r_state == FEND) r_frame_cnt <= r_frame_cnt + DATA_WIDTH'(1);
    end
`endif

    assign dvo        = r_dvo;
    assign dtypeo     = r_dtype;
    assign datao      = r_data;
    assign meta_datao = r_meta;
    assign busy       = r_busy;

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Testbench for stream_pattern_gen. A frame-level model expands each started
// frame into the exact per-cycle word list; every cycle the DUT is compared
// against it, and literal expectations pin the model on key scenarios.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH        4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START  4'd1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END    4'd2
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START    4'd3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END      4'd4
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 4'd5
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER       4'd6
`endif
`ifndef DTYPE_HEADER_END
`define DTYPE_HEADER_END   4'd7
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL        4'd8
`endif
`ifndef Image_num_cols
`define Image_num_cols     1
`endif
`ifndef Image_num_rows
`define Image_num_rows     2
`endif

module tb_stream_pattern_gen;
    localparam int PW = 10;
    localparam int DW = 16;
    localparam int CW = 11;
    localparam int HW = 8;
    localparam int RG = 4;
    localparam int FG = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [CW-1:0] num_cols = '0;
    logic [CW-1:0] num_rows = '0;
    logic [1:0]    pattern_sel = '0;
    logic [PW-1:0] const_value = '0;
    logic          dvo;
    logic [`DTYPE_WIDTH-1:0] dtypeo;
    logic [PW-1:0] datao;
    logic [DW-1:0] meta_datao;
    logic          busy;

    stream_pattern_gen #(
        .PIXEL_WIDTH(PW), .DATA_WIDTH(DW), .NUM_COLS_WIDTH(CW),
        .HEADER_WORDS(HW), .ROW_GAP(RG), .FRAME_GAP(FG)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .num_cols(num_cols), .num_rows(num_rows),
        .pattern_sel(pattern_sel), .const_value(const_value),
        .dvo(dvo), .dtypeo(dtypeo), .datao(datao),
        .meta_datao(meta_datao), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                    dv;
        logic [`DTYPE_WIDTH-1:0] dt;
        logic [PW-1:0]           d;
        logic [DW-1:0]           m;
    } item_t;

    item_t q[$];
    item_t want_i;
    logic  want_busy;
    int    fcnt;

    int errors = 0;
    int checks = 0;

    // observation logs, cleared per scenario
    int dv_cnt, busy_cnt, fs_cnt, fe_cnt, rs_cnt;
    int pix_log[$];
    int hw7_log[$];
    int hdr_cols, hdr_rows, hidx;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    function automatic item_t mk(input logic [`DTYPE_WIDTH-1:0] dt,
                                 input logic [PW-1:0] d, input logic [DW-1:0] m);
        item_t it;
        it.dv = 1'b1; it.dt = dt; it.d = d; it.m = m;
        return it;
    endfunction

    // Expand one frame into its per-cycle word list from the stream rules.
    task automatic build_frame(input int cols, input int rows, input int pat, input int cv);
        item_t z = '0;
        int    px;
        logic [DW-1:0] mv;
        q.push_back(mk(`DTYPE_FRAME_START, '0, '0));
        q.push_back(mk(`DTYPE_HEADER_START, '0, '0));
        for (int h = 0; h < HW; h++) begin
            mv = '0;
            if (h == `Image_num_cols)      mv = DW'(cols);
            else if (h == `Image_num_rows) mv = DW'(rows);
`ifdef STREAM_PATTERN_GEN_FRAME_COUNT_EN
            else if (h == HW - 1)          mv = DW'(fcnt);
`endif
            q.push_back(mk(`DTYPE_HEADER, '0, mv));
        end
        q.push_back(mk(`DTYPE_HEADER_END, '0, '0));
        for (int r = 0; r < rows; r++) begin
            q.push_back(mk(`DTYPE_ROW_START, '0, '0));
            for (int c = 0; c < cols; c++) begin
                case (pat)
                    0:       px = cv;
                    1:       px = c;
                    2:       px = r;
                    default: px = r + c;
                endcase
                q.push_back(mk(`DTYPE_PIXEL, PW'(px % (1 << PW)), '0));
            end
            q.push_back(mk(`DTYPE_ROW_END, '0, '0));
            for (int g = 0; g < RG; g++) q.push_back(z);
        end
        q.push_back(mk(`DTYPE_FRAME_END, '0, '0));
        for (int g = 0; g < FG; g++) q.push_back(z);
        fcnt++;
    endtask

    task automatic model_edge();
        if (reset) begin
            q.delete();
            fcnt      = 0;
            want_i    = '0;
            want_busy = 1'b0;
        end else begin
            if (q.size() == 0 && enable && num_cols != 0 && num_rows != 0)
                build_frame(int'(num_cols), int'(num_rows), int'(pattern_sel), int'(const_value));
            if (q.size() > 0) begin
                want_i    = q.pop_front();
                want_busy = 1'b1;
            end else begin
                want_i    = '0;
                want_busy = 1'b0;
            end
        end
    endtask

    task automatic clear_logs();
        dv_cnt = 0; busy_cnt = 0; fs_cnt = 0; fe_cnt = 0; rs_cnt = 0;
        pix_log.delete(); hw7_log.delete();
        hdr_cols = -1; hdr_rows = -1; hidx = 0;
    endtask

    // One clock: advance model at the edge, compare 1ns later, log observations.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("dvo",    32'(dvo),        32'(want_i.dv));
        chk("dtypeo", 32'(dtypeo),     32'(want_i.dt));
        chk("datao",  32'(datao),      32'(want_i.d));
        chk("meta",   32'(meta_datao), 32'(want_i.m));
        chk("busy",   32'(busy),       32'(want_busy));
        if (dvo) dv_cnt++;
        if (busy) busy_cnt++;
        if (dvo) begin
            case (dtypeo)
                `DTYPE_FRAME_START:  fs_cnt++;
                `DTYPE_FRAME_END:    fe_cnt++;
                `DTYPE_ROW_START:    rs_cnt++;
                `DTYPE_PIXEL:        pix_log.push_back(int'(datao));
                `DTYPE_HEADER_START: hidx = 0;
                `DTYPE_HEADER: begin
                    if (hidx == `Image_num_cols) hdr_cols = int'(meta_datao);
                    if (hidx == `Image_num_rows) hdr_rows = int'(meta_datao);
                    if (hidx == HW - 1)          hw7_log.push_back(int'(meta_datao));
                    hidx++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_cfg(input int c, input int r, input int p, input int cv);
        num_cols = CW'(c); num_rows = CW'(r); pattern_sel = 2'(p); const_value = PW'(cv);
    endtask

    initial begin
        int n;
        clear_logs();
        // reset state
        ticks(2);
        chk("reset_dvo", 32'(dvo), 0);
        chk("reset_busy", 32'(busy), 0);
        reset = 1'b0;

        // col ramp 4x3
        set_cfg(4, 3, 1, 0);
        clear_logs();
        enable = 1'b1;
        tick();
        chk("first_word_fs", 32'(dtypeo), 32'(`DTYPE_FRAME_START));
        enable = 1'b0;
        ticks(80);
        chk("ramp_dv_cycles", 32'(dv_cnt), 30);
        chk("ramp_pix_count", 32'(pix_log.size()), 12);
        for (int i = 0; i < pix_log.size() && i < 12; i++)
            chk("ramp_pix", 32'(pix_log[i]), 32'(i % 4));
        chk("hdr_cols", 32'(hdr_cols), 4);
        chk("hdr_rows", 32'(hdr_rows), 3);

        // diagonal 2x2
        set_cfg(2, 2, 3, 0);
        clear_logs();
        enable = 1'b1; tick(); enable = 1'b0;
        ticks(60);
        chk("diag_pix_count", 32'(pix_log.size()), 4);
        if (pix_log.size() == 4) begin
            chk("diag_p0", 32'(pix_log[0]), 0);
            chk("diag_p1", 32'(pix_log[1]), 1);
            chk("diag_p2", 32'(pix_log[2]), 1);
            chk("diag_p3", 32'(pix_log[3]), 2);
        end

        // constant 3x2, inputs changed mid-frame must not matter
        set_cfg(3, 2, 0, 'h155);
        clear_logs();
        enable = 1'b1; tick(); enable = 1'b0;
        set_cfg(7, 5, 2, 'h0aa);
        ticks(70);
        chk("const_pix_count", 32'(pix_log.size()), 6);
        for (int i = 0; i < pix_log.size(); i++)
            chk("const_pix", 32'(pix_log[i]), 32'h155);

        // enable dropped during row 1 of 3
        set_cfg(4, 3, 2, 0);
        clear_logs();
        enable = 1'b1;
        n = 0;
        while (rs_cnt < 2 && n < 200) begin tick(); n++; end
        chk("row1_reached", 32'(rs_cnt >= 2), 1);
        enable = 1'b0;
        ticks(80);
        chk("drop_fe_cnt", 32'(fe_cnt), 1);
        chk("drop_fs_cnt", 32'(fs_cnt), 1);
        chk("drop_idle", 32'(busy), 0);

        // reset during PIX, then clean restart
        set_cfg(4, 3, 1, 0);
        clear_logs();
        enable = 1'b1;
        n = 0;
        while (pix_log.size() < 2 && n < 200) begin tick(); n++; end
        chk("pix_reached", 32'(pix_log.size() >= 2), 1);
        reset = 1'b1;
        tick();
        chk("abort_dvo", 32'(dvo), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_no_fe", 32'(fe_cnt), 0);
        reset = 1'b0;
        clear_logs();
        tick();
        chk("restart_fs", 32'(dtypeo), 32'(`DTYPE_FRAME_START));
        enable = 1'b0;
        ticks(70);
        chk("restart_fe", 32'(fe_cnt), 1);
        chk("restart_pix", 32'(pix_log.size()), 12);

        // zero rows: never starts
        set_cfg(4, 0, 1, 0);
        clear_logs();
        enable = 1'b1;
        ticks(100);
        chk("zero_rows_dv", 32'(dv_cnt), 0);
        chk("zero_rows_busy", 32'(busy_cnt), 0);
        enable = 1'b0;

        // three back-to-back frames, frame-count header word
        reset = 1'b1; tick(); reset = 1'b0;
        set_cfg(2, 1, 1, 0);
        clear_logs();
        enable = 1'b1;
        ticks(3 * 36);
        enable = 1'b0;
        ticks(60);
        chk("b2b_fs_cnt", 32'(fs_cnt), 3);
        chk("hw7_count", 32'(hw7_log.size()), 3);
        if (hw7_log.size() >= 3) begin
`ifdef STREAM_PATTERN_GEN_FRAME_COUNT_EN
            chk("hw7_f0", 32'(hw7_log[0]), 0);
            chk("hw7_f1", 32'(hw7_log[1]), 1);
            chk("hw7_f2", 32'(hw7_log[2]), 2);
`else
            chk("hw7_f0", 32'(hw7_log[0]), 0);
            chk("hw7_f1", 32'(hw7_log[1]), 0);
            chk("hw7_f2", 32'(hw7_log[2]), 0);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
